// File: rtl/det_datapath_if.sv
// Host write port for the determinant datapath's coefficient memory.
interface det_datapath_if #(
    parameter int unsigned WIDTH = 8
);
    logic             mem_we;
    logic [1:0]       mem_waddr;
    logic [WIDTH-1:0] mem_wdata;

    modport master (output mem_we, output mem_waddr, output mem_wdata);
    modport slave  (input  mem_we, input  mem_waddr, input  mem_wdata);
endinterface

// File: rtl/det_datapath.sv
// Signed 2x2 determinant datapath (a*d - b*c) driven by the four-phase matrix controller.
// A shared multiplier feeds two product registers; result is their widened difference.
module det_datapath #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    det_datapath_if.slave           mem_if,
    input  logic                    en_counter_i,
    input  logic                    sel_i,
    output logic                    carry_out_o,
    output logic signed [2*WIDTH:0] result_o
);
    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned RW = 2 * WIDTH + 1;

    logic        [WIDTH-1:0] mem_q  [4];
    logic signed [WIDTH-1:0] coef_q [4];
    logic        [1:0]       cnt_q, cnt_d;
    logic signed [PW-1:0]    p0_q, p1_q;
    logic signed [RW-1:0]    result_q, result_d;

    logic signed [WIDTH-1:0] op_x, op_y;
    logic signed [PW-1:0]    op_x_ext, op_y_ext, prod;

    // Memory has no reset so host-loaded coefficients survive controller IDLE.
    always_ff @(posedge clk) begin
        if (mem_if.mem_we) begin
            mem_q[mem_if.mem_waddr] <= mem_if.mem_wdata;
        end
    end

    always_comb begin
        cnt_d       = cnt_q;
        carry_out_o = 1'b0;
        if (en_counter_i) begin
            cnt_d       = 2'(cnt_q + 2'd1);
            carry_out_o = (cnt_q == 2'd3);
        end
    end

    // Operands widened before multiplying so the PW-bit product is exact.
    always_comb begin
        op_x     = sel_i ? coef_q[1] : coef_q[0];
        op_y     = sel_i ? coef_q[2] : coef_q[3];
        op_x_ext = {{WIDTH{op_x[WIDTH-1]}}, op_x};
        op_y_ext = {{WIDTH{op_y[WIDTH-1]}}, op_y};
        prod     = op_x_ext * op_y_ext;
        result_d = {p0_q[PW-1], p0_q} - {p1_q[PW-1], p1_q};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            p0_q     <= '0;
            p1_q     <= '0;
            result_q <= '0;
            for (int i = 0; i < 4; i++) begin
                coef_q[i] <= '0;
            end
        end else begin
            cnt_q    <= cnt_d;
            result_q <= result_d;
            if (en_counter_i) begin
                coef_q[cnt_q] <= mem_q[cnt_q];
            end
            if (!sel_i && !en_counter_i) begin
                p0_q <= prod;
            end
            if (sel_i) begin
                p1_q <= prod;
            end
        end
    end

    assign result_o = result_q;
endmodule

// File: tb/tb_det_datapath.sv
// Scoreboard bench for det_datapath: expected determinants queued at run start, checked at cycle 7.
module tb_det_datapath;
    localparam int unsigned W  = 8;
    localparam int unsigned RW = 2 * W + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic                 en_counter;
    logic                 sel;
    logic                 carry_out;
    logic signed [RW-1:0] result;

    det_datapath_if #(.WIDTH(W)) hif ();

    det_datapath #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_if      (hif),
        .en_counter_i(en_counter),
        .sel_i       (sel),
        .carry_out_o (carry_out),
        .result_o    (result)
    );

    int checks   = 0;
    int failures = 0;
    int exp_q[$];

    // One controller cycle: drive, sample carry_out before the edge, advance to #1 after it.
    task automatic step(input logic en, input logic s, input logic we, input int wa, input int wd,
                        output logic c);
        en_counter    = en;
        sel           = s;
        hif.mem_we    = we;
        hif.mem_waddr = 2'(wa);
        hif.mem_wdata = W'(wd);
        #1;
        c = carry_out;
        @(posedge clk);
        #1;
        hif.mem_we = 1'b0;
    endtask

    task automatic load4(input int a, input int b, input int c, input int d);
        logic unused;
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b1, 0, a, unused);
        step(1'b0, 1'b0, 1'b1, 1, b, unused);
        step(1'b0, 1'b0, 1'b1, 2, c, unused);
        step(1'b0, 1'b0, 1'b1, 3, d, unused);
    endtask

    task automatic compute3();
        logic unused;
        step(1'b0, 1'b0, 1'b0, 0, 0, unused);
        step(1'b0, 1'b1, 1'b0, 0, 0, unused);
        step(1'b0, 1'b0, 1'b0, 0, 0, unused);
    endtask

    task automatic run_nominal(input int e, output logic [3:0] cv);
        logic c;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1'b0, 0, 0, c);
            cv[i] = c;
        end
        exp_q.push_back(e);
        compute3();
    endtask

    task automatic test_reset();
        logic c;
        rst = 1'b1;
        hif.mem_we = 1'b0;
        repeat (3) step(1'b0, 1'b0, 1'b0, 0, 0, c);
        checks++;
        if (result !== '0) begin
            failures++; $display("FAIL reset_result: got %0d expected 0", result);
        end
        checks++;
        if (c !== 1'b0) begin
            failures++; $display("FAIL reset_carry: got %b expected 0", c);
        end
        checks++;
        if (dut.cnt_q !== 2'd0) begin
            failures++; $display("FAIL reset_cnt: got %0d expected 0", dut.cnt_q);
        end
        checks++;
        if (dut.p0_q !== '0 || dut.p1_q !== '0) begin
            failures++; $display("FAIL reset_prod: got p0=%0d p1=%0d expected 0 0", dut.p0_q, dut.p1_q);
        end
    endtask

    task automatic test_basic();
        logic [3:0] cv;
        int e;
        load4(3, 2, 1, 4);
        run_nominal(10, cv);
        checks++;
        if (cv !== 4'b1000) begin
            failures++; $display("FAIL basic_carry: got %b expected 1000", cv);
        end
        checks++;
        if (exp_q.size() == 0) begin
            failures++; $display("FAIL basic_queue: got empty expected 1 entry");
            e = 0;
        end else begin
            e = exp_q.pop_front();
            if (result !== RW'(e)) begin
                failures++; $display("FAIL basic_result: got %0d expected %0d", result, e);
            end
        end
        step(1'b0, 1'b0, 1'b0, 0, 0, cv[0]);
        checks++;
        if (result !== RW'(e)) begin
            failures++; $display("FAIL basic_stable: got %0d expected %0d", result, e);
        end
    endtask

    task automatic test_signed();
        logic [3:0] cv;
        int e;
        load4(-128, 127, -128, -128);
        run_nominal(32640, cv);
        checks++;
        if (exp_q.size() == 0) begin
            failures++; $display("FAIL signed_queue: got empty expected 1 entry");
        end else begin
            e = exp_q.pop_front();
            if (result !== RW'(e)) begin
                failures++; $display("FAIL signed_result: got %0d expected %0d", result, e);
            end
        end
    endtask

    task automatic test_negative();
        logic [3:0] cv;
        int e;
        load4(1, 5, 5, 1);
        run_nominal(-24, cv);
        checks++;
        if (exp_q.size() == 0) begin
            failures++; $display("FAIL neg_queue: got empty expected 1 entry");
        end else begin
            e = exp_q.pop_front();
            if (result !== RW'(e)) begin
                failures++; $display("FAIL neg_result: got %0d expected %0d", result, e);
            end
        end
        checks++;
        if (result[RW-1:W] !== 9'h1FF) begin
            failures++; $display("FAIL neg_sign_ext: got %h expected 1ff", result[RW-1:W]);
        end
    endtask

    task automatic test_stall();
        logic [5:0] cv;
        logic       c;
        int         e;
        load4(3, 2, 1, 4);
        rst = 1'b0;
        step(1'b1, 1'b0, 1'b0, 0, 0, c); cv[0] = c;
        step(1'b1, 1'b0, 1'b0, 0, 0, c); cv[1] = c;
        step(1'b0, 1'b0, 1'b0, 0, 0, c); cv[2] = c;
        step(1'b0, 1'b0, 1'b0, 0, 0, c); cv[3] = c;
        checks++;
        if (dut.cnt_q !== 2'd2) begin
            failures++; $display("FAIL stall_cnt: got %0d expected 2", dut.cnt_q);
        end
        step(1'b1, 1'b0, 1'b0, 0, 0, c); cv[4] = c;
        step(1'b1, 1'b0, 1'b0, 0, 0, c); cv[5] = c;
        checks++;
        if (cv !== 6'b100000) begin
            failures++; $display("FAIL stall_carry: got %b expected 100000", cv);
        end
        exp_q.push_back(10);
        compute3();
        checks++;
        if (exp_q.size() == 0) begin
            failures++; $display("FAIL stall_queue: got empty expected 1 entry");
        end else begin
            e = exp_q.pop_front();
            if (result !== RW'(e)) begin
                failures++; $display("FAIL stall_result: got %0d expected %0d", result, e);
            end
        end
    endtask

    task automatic test_rst_mid();
        logic [3:0] cv;
        logic [W-1:0] mem_exp [4];
        logic c;
        int e;
        mem_exp = '{8'd6, 8'd2, 8'd3, 8'd5};
        load4(6, 2, 3, 5);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 0, 0, c);
        exp_q.push_back(24);
        step(1'b0, 1'b0, 1'b0, 0, 0, c);
        checks++;
        if (dut.p0_q !== 16'sd30) begin
            failures++; $display("FAIL rstmid_p0_pre: got %0d expected 30", dut.p0_q);
        end
        rst = 1'b1;
        step(1'b0, 1'b1, 1'b0, 0, 0, c);
        e = exp_q.pop_front();
        checks++;
        if (result !== '0 || dut.p0_q !== '0 || dut.p1_q !== '0 || dut.cnt_q !== 2'd0) begin
            failures++;
            $display("FAIL rstmid_clear: got result=%0d p0=%0d p1=%0d cnt=%0d expected all 0",
                     result, dut.p0_q, dut.p1_q, dut.cnt_q);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (dut.mem_q[i] !== mem_exp[i]) begin
                failures++; $display("FAIL rstmid_mem%0d: got %0d expected %0d", i, dut.mem_q[i], mem_exp[i]);
            end
        end
        run_nominal(24, cv);
        checks++;
        if (exp_q.size() == 0) begin
            failures++; $display("FAIL rstmid_queue: got empty expected 1 entry");
        end else begin
            e = exp_q.pop_front();
            if (result !== RW'(e)) begin
                failures++; $display("FAIL rstmid_rerun: got %0d expected %0d", result, e);
            end
        end
    endtask

    task automatic test_host_write();
        logic [3:0] cv;
        logic c;
        int e;
        load4(3, 2, 1, 4);
        rst = 1'b0;
        step(1'b1, 1'b0, 1'b0, 0, 0, c);
        step(1'b1, 1'b0, 1'b1, 3, 9, c);
        step(1'b1, 1'b0, 1'b1, 0, 7, c);
        step(1'b1, 1'b0, 1'b0, 0, 0, c);
        exp_q.push_back(25);
        compute3();
        checks++;
        if (exp_q.size() == 0) begin
            failures++; $display("FAIL hostwr_queue: got empty expected 1 entry");
        end else begin
            e = exp_q.pop_front();
            if (result !== RW'(e)) begin
                failures++; $display("FAIL hostwr_run1: got %0d expected %0d", result, e);
            end
        end
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0, 0, 0, c);
        run_nominal(61, cv);
        checks++;
        if (exp_q.size() == 0) begin
            failures++; $display("FAIL hostwr_queue2: got empty expected 1 entry");
        end else begin
            e = exp_q.pop_front();
            if (result !== RW'(e)) begin
                failures++; $display("FAIL hostwr_run2: got %0d expected %0d", result, e);
            end
        end
    endtask

    initial begin
        rst           = 1'b1;
        en_counter    = 1'b0;
        sel           = 1'b0;
        hif.mem_we    = 1'b0;
        hif.mem_waddr = 2'd0;
        hif.mem_wdata = '0;
        test_reset();
        test_basic();
        test_signed();
        test_negative();
        test_stall();
        test_rst_mid();
        test_host_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/det_datapath.md
# det_datapath

Datapath paired with the four-phase matrix controller. It holds a host-loadable 4-word coefficient memory [a, b, c, d] and computes the signed 2x2 determinant a*d - b*c. The controller drives it through `rst`, `en_counter` and `sel`, and the datapath returns `carry_out`. The controller's `done` output marks when `result` is valid.

## Interface

- `WIDTH`, default 8: width of each signed coefficient word (two's complement).
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high. Driven by the controller (high in IDLE). Clears the counter, coefficient registers, product registers and `result`. Does not clear the memory.
- `mem_we` input 1: host write strobe for the coefficient memory.
- `mem_waddr` input 2: host write address (0=a, 1=b, 2=c, 3=d).
- `mem_wdata` input WIDTH: host write data.
- `en_counter` input 1: from the controller. Read-phase enable: load `mem[cnt]` and advance the counter.
- `sel` input 1: from the controller. Multiplier operand select: 0 selects a*d, 1 selects b*c.
- `carry_out` output 1: to the controller. Combinational; equals `en_counter && cnt == 3`.
- `result` output 2*WIDTH+1: signed determinant, registered.

## Operation

- **Memory**
  - 4 x WIDTH registers, written when `mem_we`=1 at `mem_waddr`.
  - No reset; contents persist across `rst`.
  - A write and a read of the same address in the same cycle returns the old word (read-before-write).
- **Counter `cnt`**
  - 2 bits, reset 0.
  - When `en_counter`=1: `cnt <= cnt+1`, wrapping 3 -> 0.
  - Held otherwise.
- **Coefficient registers a, b, c, d**
  - Reset 0.
  - When `en_counter`=1, the register indexed by `cnt` loads `mem[cnt]`.
- **Multiplier**
  - One shared signed WIDTH x WIDTH -> 2*WIDTH multiplier.
  - Operands are (a, d) when `sel`=0 and (b, c) when `sel`=1.
- **Product registers p0, p1**
  - 2*WIDTH signed, reset 0.
  - p0 loads the product every cycle `sel`=0 and `en_counter`=0.
  - p1 loads the product every cycle `sel`=1.
- **Result**
  - Loads `p0 - p1` every cycle `rst`=0.
  - Both operands are sign-extended to 2*WIDTH+1, so the subtraction never overflows.
- **`rst` has priority** over every other enable.

## Timing

- **Reset values:** `result`=0. `carry_out`=0 whenever `en_counter`=0.
- **Nominal sequence** (cycle 0 = first controller state after IDLE):
  - Cycles 0-3, read_memory (`en_counter`=1): a, b, c, d loaded in order. `carry_out`=1 in cycle 3 only.
  - Cycle 4, first multiply (`sel`=0): p0 <= a*d at the edge.
  - Cycle 5, second multiply (`sel`=1): p1 <= b*c.
  - Cycle 6, subtraction: `result` <= p0 - p1.
  - Cycle 7 onward, finish: `result` valid and stable while coefficients are unchanged.
  - Latency: 7 edges from the first `en_counter` cycle to a valid `result`.
- **`en_counter` dropped mid-read:** the counter holds and no `carry_out` is produced. Reading resumes at the same `cnt`.
- **`rst` mid-operation:** all datapath state returns to 0 on the next edge, and the next read starts at a (`cnt`=0).
- **Host write during the read phase:** affects only words whose address has not yet been read. An address already read keeps its latched value until the next run.
- **`en_counter` and `sel` both 1:** not produced by the controller. The read load and the p1 load both occur, and p0 does not load.

## Test plan

- Load a=3, b=2, c=1, d=4; pulse the read phase for 4 cycles, then `sel`=0, `sel`=1, one idle cycle. Required: `carry_out` high only in read cycle 3, and `result`=10 at cycle 7.
- Signed, WIDTH=8: a=-128, d=-128, b=127, c=-128. Required: `result` = 16384 - (-16256) = 32640, with no overflow.
- Negative result: a=1, d=1, b=5, c=5. Required: `result`=-24 (all-ones sign extension in the upper bits).
- Drop `en_counter` for 2 cycles after reading b. Required: `cnt` holds at 2, `carry_out` stays low, and the final `result` is identical to the uninterrupted run.
- Assert `rst` during the second multiply. Required: `result`, p0 and p1 are 0 the next cycle, memory is unchanged, and a rerun gives the correct determinant.
- Host writes d=9 in read cycle 1, then writes a=7 in read cycle 2 after a was already read. Required: the run uses d=9 and the old a. A second run uses a=7.
